// File: rtl/uart_frame_datas.sv
// 8N1 full-duplex UART moving BYTES-character frames: TX serialises a W-bit word byte0 first,
// RX reassembles BYTES characters into one word, dropping glitches, framing errors and stalls.
module uart_frame_datas #(
  parameter int SCYCLE   = 50_000_000,
  parameter int BAUDRATE = 115200,
  parameter int BYTES    = 8
) (
  input  logic               iClock,
  input  logic               iNreset,
  input  logic               iSendReq,
  input  logic [8*BYTES-1:0] iSendDatas,
  output logic               oSendBusy,
  output logic               oSendDone,
  output logic               oTx,
  output logic               oRecvRecepttion,
  output logic [8*BYTES-1:0] orecvDatas,
  output logic               oRecvDone,
  input  logic               iRx
);
  localparam int W       = 8 * BYTES;
  localparam int BIT_CYC = SCYCLE / BAUDRATE;
  localparam int TO_CYC  = 20 * BIT_CYC;
  localparam int CW      = $clog2(TO_CYC + 1);
  localparam int BW      = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [CW-1:0] BIT_END   = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_END  = CW'(BIT_CYC / 2 - 1);
  localparam logic [CW-1:0] TO_END    = CW'(TO_CYC - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(BYTES - 1);

  // ---------------- transmitter ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} txState_t;
  txState_t        txState, txNext;
  logic [CW-1:0]   txCnt;
  logic [2:0]      txBit;
  logic [BW-1:0]   txByte;
  logic [W-1:0]    txShift;
  logic            txBitEnd;

  assign txBitEnd = (txCnt == BIT_END);

  always_ff @(posedge iClock or negedge iNreset)
    if (!iNreset) txState <= TX_IDLE;
    else          txState <= txNext;

  always_comb begin
    txNext = txState;
    case (txState)
      TX_IDLE:  if (iSendReq) txNext = TX_START;
      TX_START: if (txBitEnd) txNext = TX_DATA;
      TX_DATA:  if (txBitEnd && txBit == 3'd7) txNext = TX_STOP;
      TX_STOP:  if (txBitEnd) txNext = (txByte == LAST_BYTE) ? TX_DONE : TX_START;
      TX_DONE:  txNext = TX_IDLE;
      default:  txNext = TX_IDLE;
    endcase
  end

  always_comb begin
    oTx       = 1'b1;
    oSendBusy = 1'b0;
    oSendDone = 1'b0;
    case (txState)
      TX_START: begin oTx = 1'b0;       oSendBusy = 1'b1; end
      TX_DATA:  begin oTx = txShift[0]; oSendBusy = 1'b1; end
      TX_STOP:  oSendBusy = 1'b1;
      TX_DONE:  oSendDone = 1'b1;
      default:  ;
    endcase
  end

  // Eight right shifts per character bring the next byte down into [7:0].
  always_ff @(posedge iClock or negedge iNreset)
    if (!iNreset) begin
      txCnt   <= '0;
      txBit   <= '0;
      txByte  <= '0;
      txShift <= '0;
    end else begin
      if (txState == TX_IDLE || txState == TX_DONE || txBitEnd) txCnt <= '0;
      else                                                     txCnt <= txCnt + 1'b1;
      if (txState == TX_IDLE && iSendReq) begin
        txShift <= iSendDatas;
        txByte  <= '0;
        txBit   <= '0;
      end
      if (txState == TX_DATA && txBitEnd) begin
        txShift <= txShift >> 1;
        txBit   <= txBit + 3'd1;
      end
      if (txState == TX_STOP && txBitEnd) txByte <= txByte + 1'b1;
    end

  // ---------------- receiver ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rxState_t;
  rxState_t        rxState, rxNext;
  logic            rxMeta, rxSync, rxPrev, rxFall;
  logic [CW-1:0]   rxCnt;
  logic [2:0]      rxBit;
  logic [BW-1:0]   rxByteIdx;
  logic [6:0]      rxSh;
  logic [W-1:0]    rxWord;
  logic            rxBitEnd;

  assign rxFall   = rxPrev & ~rxSync;
  assign rxBitEnd = (rxCnt == BIT_END);

  always_ff @(posedge iClock or negedge iNreset)
    if (!iNreset) begin
      rxMeta <= 1'b1;
      rxSync <= 1'b1;
      rxPrev <= 1'b1;
    end else begin
      rxMeta <= iRx;
      rxSync <= rxMeta;
      rxPrev <= rxSync;
    end

  always_ff @(posedge iClock or negedge iNreset)
    if (!iNreset) rxState <= RX_IDLE;
    else          rxState <= rxNext;

  // A non-zero byte index means a frame is open, so a glitch returns to WAIT instead of IDLE.
  always_comb begin
    rxNext = rxState;
    case (rxState)
      RX_IDLE:  if (rxFall) rxNext = RX_START;
      RX_START: if (rxCnt == HALF_END)
                  rxNext = !rxSync ? RX_DATA : (rxByteIdx == '0) ? RX_IDLE : RX_WAIT;
      RX_DATA:  if (rxBitEnd && rxBit == 3'd7) rxNext = RX_STOP;
      RX_STOP:  if (rxBitEnd)
                  rxNext = (!rxSync || rxByteIdx == LAST_BYTE) ? RX_IDLE : RX_WAIT;
      RX_WAIT:  if (rxFall) rxNext = RX_START;
                else if (rxCnt == TO_END) rxNext = RX_IDLE;
      default:  rxNext = RX_IDLE;
    endcase
  end

  always_comb begin
    oRecvRecepttion = (rxState != RX_IDLE);
  end

  always_ff @(posedge iClock or negedge iNreset)
    if (!iNreset) begin
      rxCnt      <= '0;
      rxBit      <= '0;
      rxByteIdx  <= '0;
      rxSh       <= '0;
      rxWord     <= '0;
      orecvDatas <= '0;
      oRecvDone  <= 1'b0;
    end else begin
      oRecvDone <= 1'b0;
      if (rxState == RX_IDLE || rxNext != rxState || (rxState == RX_DATA && rxBitEnd))
        rxCnt <= '0;
      else
        rxCnt <= rxCnt + 1'b1;
      if (rxState != RX_START && rxNext == RX_START) rxBit <= '0;
      if (rxState == RX_DATA && rxBitEnd) begin
        rxSh  <= {rxSync, rxSh[6:1]};
        rxBit <= rxBit + 3'd1;
        if (rxBit == 3'd7) rxWord[{rxByteIdx, 3'b000} +: 8] <= {rxSync, rxSh};
      end
      if (rxState == RX_STOP && rxBitEnd) begin
        if (!rxSync) rxByteIdx <= '0;
        else if (rxByteIdx == LAST_BYTE) begin
          rxByteIdx  <= '0;
          orecvDatas <= rxWord;
          oRecvDone  <= 1'b1;
        end else rxByteIdx <= rxByteIdx + 1'b1;
      end
      if (rxState == RX_WAIT && !rxFall && rxCnt == TO_END) rxByteIdx <= '0;
    end
endmodule

// File: tb/tb_uart_frame_datas.sv
// Directed bench for uart_frame_datas at 16 clocks per bit: frame serialisation, loopback,
// ignored mid-frame requests, async reset, RX glitch/timeout and framing-error rejection.
module tb_uart_frame_datas;
  localparam int BYTES = 8;
  localparam int W     = 8 * BYTES;
  localparam int BC    = 16;
  localparam int NBITS = BYTES * 10;
  localparam int FRAME = NBITS * BC;

  logic         iClock = 1'b0, iNreset = 1'b0, iSendReq = 1'b0;
  logic [W-1:0] iSendDatas = '0;
  logic         oSendBusy, oSendDone, oTx, oRecvRecepttion, oRecvDone, iRx;
  logic [W-1:0] orecvDatas;
  logic         loopEn = 1'b0, rxDrv = 1'b1;

  assign iRx = loopEn ? oTx : rxDrv;
  always #5 iClock = ~iClock;

  uart_frame_datas #(.SCYCLE(1_600_000), .BAUDRATE(100_000), .BYTES(BYTES)) dut (
    .iClock(iClock), .iNreset(iNreset), .iSendReq(iSendReq), .iSendDatas(iSendDatas),
    .oSendBusy(oSendBusy), .oSendDone(oSendDone), .oTx(oTx),
    .oRecvRecepttion(oRecvRecepttion), .orecvDatas(orecvDatas), .oRecvDone(oRecvDone),
    .iRx(iRx));

  int vectors = 0, miscompares = 0;
  int recvDoneCnt = 0, sendDoneCnt = 0;

  always @(negedge iClock) begin
    if (oRecvDone) recvDoneCnt++;
    if (oSendDone) sendDoneCnt++;
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge iClock);
  endtask

  task automatic rxChar(input logic [7:0] b, input logic stopBit);
    rxDrv = 1'b0;
    tick(BC);
    for (int i = 0; i < 8; i++) begin
      rxDrv = b[i];
      tick(BC);
    end
    rxDrv = stopBit;
    tick(BC);
    rxDrv = 1'b1;
  endtask

  initial begin
    logic [W-1:0]       d;
    logic [NBITS-1:0]   firstS, lastS;
    logic [9:0]         ch;
    logic               busyDrop, seen;
    int                 r0, s0;

    firstS = '0; lastS = '0;
    tick(2);
    check("rst_tx", oTx, 1);
    check("rst_busy", oSendBusy, 0);
    check("rst_sdone", oSendDone, 0);
    check("rst_recep", oRecvRecepttion, 0);
    check("rst_rdata", orecvDatas, 0);
    check("rst_rdone", oRecvDone, 0);
    iNreset = 1'b1;
    tick(3);

    // Frame in loopback, with a second request pulsed mid-frame
    loopEn = 1'b1;
    d = 64'h0FDC_BA98_7654_3210;
    r0 = recvDoneCnt; s0 = sendDoneCnt;
    iSendDatas = d; iSendReq = 1'b1;
    tick(1);
    iSendReq = 1'b0;
    check("busy_rise", oSendBusy, 1);
    check("start_bit", oTx, 0);
    busyDrop = 1'b0;
    for (int c = 0; c < FRAME; c++) begin
      if (c == 300) begin iSendReq = 1'b1; iSendDatas = 64'hA5A5_A5A5_A5A5_A5A5; end
      if (c == 301) iSendReq = 1'b0;
      if (!oSendBusy || oSendDone) busyDrop = 1'b1;
      if (c % BC == 0)      firstS[c / BC] = oTx;
      if (c % BC == BC - 1) lastS[c / BC]  = oTx;
      tick(1);
    end
    check("sdone_at_frame_end", oSendDone, 1);
    check("busy_fall", oSendBusy, 0);
    check("busy_held", busyDrop, 0);
    for (int b = 0; b < BYTES; b++) begin
      ch = {1'b1, d[8*b +: 8], 1'b0};
      check($sformatf("char%0d_head", b), firstS[10*b +: 10], ch);
      check($sformatf("char%0d_tail", b), lastS[10*b +: 10], ch);
    end
    tick(1);
    check("sdone_one_cycle", oSendDone, 0);
    tick(20);
    check("no_second_frame", oSendBusy, 0);
    check("sdone_count", 64'(sendDoneCnt - s0), 1);
    check("loop_rdone_count", 64'(recvDoneCnt - r0), 1);
    check("loop_rdata", orecvDatas, d);

    // Reset mid-byte while a zero data bit is on the line
    iSendDatas = 64'h1122_3344_5566_7700; iSendReq = 1'b1;
    tick(1);
    iSendReq = 1'b0;
    tick(50);
    check("pre_rst_tx", oTx, 0);
    check("pre_rst_recep", oRecvRecepttion, 1);
    iNreset = 1'b0;
    #1;
    check("midrst_tx", oTx, 1);
    check("midrst_busy", oSendBusy, 0);
    check("midrst_recep", oRecvRecepttion, 0);
    check("midrst_rdata", orecvDatas, 0);
    tick(2);
    iNreset = 1'b1;
    tick(2);
    d = 64'hDEAD_BEEF_CAFE_F00D;
    r0 = recvDoneCnt;
    iSendDatas = d; iSendReq = 1'b1;
    tick(1);
    iSendReq = 1'b0;
    check("post_rst_busy", oSendBusy, 1);
    tick(FRAME);
    check("post_rst_sdone", oSendDone, 1);
    tick(20);
    check("post_rst_rdone_count", 64'(recvDoneCnt - r0), 1);
    check("post_rst_rdata", orecvDatas, d);

    // Short low pulse on RX: rejected at the mid-start check
    loopEn = 1'b0; rxDrv = 1'b1;
    tick(5);
    r0 = recvDoneCnt; seen = 1'b0;
    rxDrv = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c == 4) rxDrv = 1'b1;
      if (oRecvRecepttion) seen = 1'b1;
      tick(1);
    end
    check("glitch_recep_seen", seen, 1);
    check("glitch_recep_end", oRecvRecepttion, 0);
    check("glitch_no_rdone", 64'(recvDoneCnt - r0), 0);

    // 100-clock low: one character, then the inter-character timeout drops it
    seen = 1'b0;
    rxDrv = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (c == 100) rxDrv = 1'b1;
      if (oRecvRecepttion) seen = 1'b1;
      tick(1);
    end
    check("long_recep_seen", seen, 1);
    check("timeout_recep_end", oRecvRecepttion, 0);
    check("timeout_no_rdone", 64'(recvDoneCnt - r0), 0);
    check("timeout_rdata_kept", orecvDatas, d);

    // Full frame whose last stop bit is 0, then a clean frame
    tick(10);
    d = 64'h8877_6655_4433_2211;
    for (int b = 0; b < BYTES; b++) rxChar(d[8*b +: 8], (b == BYTES - 1) ? 1'b0 : 1'b1);
    tick(40);
    check("ferr_no_rdone", 64'(recvDoneCnt - r0), 0);
    check("ferr_rdata_kept", orecvDatas, 64'hDEAD_BEEF_CAFE_F00D);
    check("ferr_recep", oRecvRecepttion, 0);
    for (int b = 0; b < BYTES; b++) rxChar(d[8*b +: 8], 1'b1);
    tick(40);
    check("clean_rdone_count", 64'(recvDoneCnt - r0), 1);
    check("clean_rdata", orecvDatas, d);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
